vga_text_writer: RTL and testbench
==================================

// Module: vga_text_writer
// PURPOSE
//  Write-side agent for the 80x30 text-mode video RAM that the VGA scan-out path reads.
//  Accepts a byte stream over a valid/ready handshake and keeps a hardware cursor.
//  Stores printable bytes at the cursor and interprets control bytes (LF, CR, BS, FF).
//  Blanks the whole screen at reset, and blanks each newly entered row.
//  Drives the write port of the dual-port VRAM; scan-out owns the read port.
// PARAMETERS
//  COLS   80     visible text columns; vram column field is 7 bits, COLS <= 128
//  ROWS   30     visible text rows; vram row field is 5 bits, ROWS <= 32
//  BLANK  8'h20  fill byte used for screen clear, line clear and backspace
// PORTS
//  clk_i          in   1   25.2MHz pixel clock, same clock as scan-out
//  reset_ni       in   1   asynchronous, active-low reset
//  char_valid_i   in   1   char_data_i holds a byte to consume
//  char_data_i    in   8   byte_t; printable byte or control code
//  char_ready_o   out  1   block accepts a byte this cycle
//  vram_we_o      out  1   write strobe for the VRAM write port
//  vram_addr_o    out  12  {row[4:0], col[6:0]}; matches the scan-out address map
//  vram_data_o    out  8   byte to write
//  cursor_row_o   out  5   current cursor row, for a cursor overlay
//  cursor_col_o   out  7   current cursor column
//  busy_o         out  1   high in CLEAR or CLEAR_LINE
// BEHAVIOUR
//  Handshake: a byte is accepted on a rising edge where char_valid_i && char_ready_o.
//   The source holds the byte stable until it is accepted.
//  All outputs are registered. Async reset drives every output to 0 and puts the FSM in CLEAR with clr=0.
//  FSM states CLEAR, IDLE and CLEAR_LINE. char_ready_o = (state==IDLE); busy_o = !char_ready_o.
//  CLEAR: on each edge, write BLANK to clr={row,col}, scanning col 0..COLS-1, then row 0..ROWS-1.
//   The edge that registers the last write (ROWS-1, COLS-1) also moves the FSM to IDLE and sets cursor=(0,0).
//  IDLE, byte accepted at edge t. The effect is registered at edge t and visible in cycle t+1:
//   0x0A LF: col=0, row=(row==ROWS-1)?0:row+1, no write; go to CLEAR_LINE for the new row.
//   0x0D CR: col=0, no write.
//   0x08 BS: if col>0, col-=1 and write BLANK at the new col. At col 0, no write and no move.
//   0x0C FF: no write; enter CLEAR with clr=0, cursor=(0,0).
//   any other byte: write it at (row,col).
//    If col<COLS-1: col+=1.
//    Else: col=0, row advances with wrap as for LF, then CLEAR_LINE.
//  No acceptance: vram_we_o=0 in the following cycle. Back-to-back bytes in IDLE give one write per cycle.
//  CLEAR_LINE: on each edge, write BLANK to (row, lc) for lc=0..COLS-1.
//   The edge that registers the last write returns the FSM to IDLE.
//   Ready is low for exactly COLS cycles after the triggering byte's cycle.
//  There is no scrolling. After row ROWS-1 the cursor wraps to row 0, which is blanked first.
//  Reset mid-operation: the FSM abandons any clear and restarts CLEAR from (0,0) when reset releases.
//   vram_we_o falls asynchronously when reset asserts.
//  Cursor ports always show the post-update cursor, in the same cycle as the associated write.
// STRUCTURE
//  Add to package common:
//   localparams TEXT_COLS=80 and TEXT_ROWS=30.
//   typedef vram_addr_t (logic [11:0]).
//   typedef text_pos_t (struct {row[4:0], col[6:0]}).
//   Control-code constants CHAR_LF, CHAR_CR, CHAR_BS, CHAR_FF.
//  No sub-module. One FSM with a shared clear counter that serves both CLEAR and CLEAR_LINE.
//  The scan-out side derives its read address from the same text_pos_t layout.
// TESTING
//  1 Reset release -> 2400 writes of 0x20.
//    Addresses run 0x000..0x04F, 0x080..0x0CF, and so on, up to 0xECF.
//    Ready stays low until the 0xECF write, then goes high.
//  2 After clear, send 0x41 -> next cycle: we=1, addr=0x000, data=0x41, cursor=(0,1).
//  3 80 bytes back-to-back from (0,0) -> writes 0x000..0x04F.
//    Then 80 blank writes 0x080..0x0CF with ready low. Cursor ends at (1,0).
//  4 Cursor at (29,7), send LF -> cursor (0,0), then blank writes 0x000..0x04F, no char write.
//  5 Cursor at (2,5): BS -> write 0x20 @0x104, cursor (2,4). CR -> cursor (2,0), no write.
//    BS at col 0 -> no write, cursor unchanged.
//  6 Assert reset_ni=0 mid CLEAR_LINE -> we drops at once.
//    On release, full CLEAR restarts from addr 0x000. FF in IDLE -> identical full clear.

Source files
------------

// File: rtl/common.sv
// Shared text-mode types and constants used by the VRAM writer and the scan-out side.
package common;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;

  typedef logic [7:0]  byte_t;
  typedef logic [11:0] vram_addr_t;

  typedef struct packed {
    logic [4:0] row;
    logic [6:0] col;
  } text_pos_t;

  localparam byte_t CHAR_LF    = 8'h0A;
  localparam byte_t CHAR_CR    = 8'h0D;
  localparam byte_t CHAR_BS    = 8'h08;
  localparam byte_t CHAR_FF    = 8'h0C;
  localparam byte_t CHAR_BLANK = 8'h20;

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_IDLE       = 2'd1,
    ST_CLEAR_LINE = 2'd2
  } wr_state_e;

  // Row advance with wrap back to the top; there is no scrolling.
  function automatic logic [4:0] next_row(input logic [4:0] row, input logic [4:0] last_row);
    return (row == last_row) ? 5'd0 : row + 5'd1;
  endfunction

endpackage

// File: rtl/vga_text_writer_if.sv
// Byte-stream valid/ready channel feeding the text writer.
interface vga_text_writer_if;
  import common::*;

  logic  valid;
  byte_t data;
  logic  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vga_text_writer.sv
// Write-side agent for the text-mode VRAM: cursor tracking, control codes and
// screen/line blanking through one shared clear counter.
module vga_text_writer
  import common::*;
#(
  parameter int    COLS  = TEXT_COLS,
  parameter int    ROWS  = TEXT_ROWS,
  parameter byte_t BLANK = CHAR_BLANK
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  vga_text_writer_if.slave         char_if,
  output logic                     vram_we_o,
  output vram_addr_t               vram_addr_o,
  output byte_t                    vram_data_o,
  output logic [4:0]               cursor_row_o,
  output logic [6:0]               cursor_col_o,
  output logic                     busy_o
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  wr_state_e  state_q, state_d;
  text_pos_t  clr_q, clr_d;
  text_pos_t  cursor_q, cursor_d;
  logic       we_q, we_d;
  vram_addr_t addr_q, addr_d;
  byte_t      data_q, data_d;
  logic       ready_q;
  logic       busy_q;
  logic       accept_s;

  assign accept_s = char_if.valid && ready_q;

  // Next-state, cursor and VRAM write-port decode.
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    cursor_d = cursor_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = vram_addr_t'(clr_q);
        data_d = BLANK;
        if (clr_q.col == LAST_COL) begin
          clr_d.col = 7'd0;
          if (clr_q.row == LAST_ROW) begin
            clr_d.row = 5'd0;
            state_d   = ST_IDLE;
            cursor_d  = '0;
          end else begin
            clr_d.row = clr_q.row + 5'd1;
          end
        end else begin
          clr_d.col = clr_q.col + 7'd1;
        end
      end

      ST_CLEAR_LINE: begin
        we_d   = 1'b1;
        addr_d = {cursor_q.row, clr_q.col};
        data_d = BLANK;
        if (clr_q.col == LAST_COL) begin
          clr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          clr_d.col = clr_q.col + 7'd1;
        end
      end

      ST_IDLE: begin
        if (accept_s) begin
          case (char_if.data)
            CHAR_LF: begin
              cursor_d.col = 7'd0;
              cursor_d.row = next_row(cursor_q.row, LAST_ROW);
              clr_d        = '0;
              state_d      = ST_CLEAR_LINE;
            end
            CHAR_CR: begin
              cursor_d.col = 7'd0;
            end
            CHAR_BS: begin
              if (cursor_q.col != 7'd0) begin
                cursor_d.col = cursor_q.col - 7'd1;
                we_d         = 1'b1;
                addr_d       = {cursor_q.row, cursor_q.col - 7'd1};
                data_d       = BLANK;
              end else begin
                cursor_d = cursor_q;
              end
            end
            CHAR_FF: begin
              cursor_d = '0;
              clr_d    = '0;
              state_d  = ST_CLEAR;
            end
            default: begin
              we_d   = 1'b1;
              addr_d = vram_addr_t'(cursor_q);
              data_d = char_if.data;
              if (cursor_q.col < LAST_COL) begin
                cursor_d.col = cursor_q.col + 7'd1;
              end else begin
                // Wrapping off the right edge enters a fresh row, which is blanked first.
                cursor_d.col = 7'd0;
                cursor_d.row = next_row(cursor_q.row, LAST_ROW);
                clr_d        = '0;
                state_d      = ST_CLEAR_LINE;
              end
            end
          endcase
        end else begin
          we_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_CLEAR;
      clr_q    <= '0;
      cursor_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      cursor_q <= cursor_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign char_if.ready = ready_q;
  assign vram_we_o     = we_q;
  assign vram_addr_o   = addr_q;
  assign vram_data_o   = data_q;
  assign cursor_row_o  = cursor_q.row;
  assign cursor_col_o  = cursor_q.col;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: full clear, printing, line wrap, control codes, reset.
module tb_vga_text_writer;
  import common::*;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [11:0] addr;
  logic [7:0] data;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  int checks;
  int errors;

  vga_text_writer_if char_if();

  vga_text_writer dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .char_if      (char_if),
    .vram_we_o    (we),
    .vram_addr_o  (addr),
    .vram_data_o  (data),
    .cursor_row_o (cur_row),
    .cursor_col_o (cur_col),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check(tag, {cur_row, cur_col}, {5'(row), 7'(col)});
  endtask

  // Expects 2400 blank writes in raster order, ready rising with the last one.
  task automatic expect_clear(input string tag);
    for (int i = 0; i < 2400; i++) begin
      logic last;
      @(posedge clk); #1;
      last = (i == 2399);
      check(tag, {ready_bit(), busy, we, addr, data},
            {last, ~last, 1'b1, 5'(i / 80), 7'(i % 80), 8'h20});
    end
  endtask

  function automatic logic ready_bit();
    return char_if.ready;
  endfunction

  task automatic line_clear(input string tag, input int row);
    for (int lc = 0; lc < 80; lc++) begin
      logic last;
      @(posedge clk); #1;
      last = (lc == 79);
      check(tag, {ready_bit(), busy, we, addr, data},
            {last, ~last, 1'b1, 5'(row), 7'(lc), 8'h20});
    end
  endtask

  // Presents one byte with ready high; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    check("rdy_before_send", {31'd0, char_if.ready}, 32'd1);
    char_if.valid = 1'b1;
    char_if.data  = b;
    @(posedge clk); #1;
    char_if.valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    char_if.valid = 1'b0;
    char_if.data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {char_if.ready, busy, we, addr, data}, 32'd0);
    check_cursor("reset_cursor", 0, 0);

    // 1: power-up clear
    @(negedge clk) rst_n = 1'b1;
    expect_clear("init_clear");
    check_cursor("cursor_after_clear", 0, 0);

    // 2: single printable byte
    send(8'h41);
    check("char_write", {we, addr, data}, {1'b1, 12'h000, 8'h41});
    check_cursor("cursor_after_A", 0, 1);
    @(posedge clk); #1;
    check("idle_no_write", {31'd0, we}, 32'd0);

    // 3: one full row back-to-back, then the next row is blanked
    send(CHAR_CR);
    check("cr_no_write", {31'd0, we}, 32'd0);
    check_cursor("cursor_after_cr", 0, 0);
    for (int i = 0; i < 80; i++) begin
      send(8'(8'h30 + i));
      check("row_write", {we, addr, data}, {1'b1, 5'd0, 7'(i), 8'(8'h30 + i)});
      if (i < 79) check_cursor("row_cursor", 0, i + 1);
      else check_cursor("wrap_cursor", 1, 0);
    end
    check("ready_low_after_wrap", {31'd0, char_if.ready}, 32'd0);
    line_clear("wrap_line_clear", 1);
    check_cursor("cursor_after_line_clear", 1, 0);

    // 4: walk to (29,7) and LF wraps to row 0
    for (int r = 2; r < 30; r++) begin
      send(CHAR_LF);
      check("lf_no_write", {31'd0, we}, 32'd0);
      line_clear("lf_line_clear", r);
    end
    for (int i = 0; i < 7; i++) send(8'h78);
    check_cursor("cursor_29_7", 29, 7);
    send(CHAR_LF);
    check("lf_wrap_no_write", {31'd0, we}, 32'd0);
    check_cursor("cursor_lf_wrap", 0, 0);
    line_clear("row0_line_clear", 0);

    // 5: backspace / carriage return
    send(CHAR_LF); line_clear("lf1", 1);
    send(CHAR_LF); line_clear("lf2", 2);
    for (int i = 0; i < 5; i++) send(8'h62);
    check_cursor("cursor_2_5", 2, 5);
    send(CHAR_BS);
    check("bs_write", {we, addr, data}, {1'b1, 12'h104, 8'h20});
    check_cursor("cursor_after_bs", 2, 4);
    send(CHAR_CR);
    check("cr2_no_write", {31'd0, we}, 32'd0);
    check_cursor("cursor_after_cr2", 2, 0);
    send(CHAR_BS);
    check("bs_col0_no_write", {31'd0, we}, 32'd0);
    check_cursor("cursor_bs_col0", 2, 0);
    check("ready_after_bs_col0", {31'd0, char_if.ready}, 32'd1);

    // 6: reset during a line clear, then form feed
    send(CHAR_LF);
    repeat (10) @(posedge clk);
    #1;
    check("mid_line_we", {31'd0, we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_we_drop", {char_if.ready, busy, we}, 32'd0);
    check_cursor("cursor_in_reset", 0, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    expect_clear("reset_clear");
    send(8'h5A);
    send(CHAR_FF);
    check("ff_no_write", {char_if.ready, we}, 32'd0);
    check_cursor("cursor_after_ff", 0, 0);
    expect_clear("ff_clear");
    check_cursor("cursor_after_ff_clear", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
